// File: rtl/ifft8_seq.sv
// ifft8_seq: sequential radix-2 DIT 8-point inverse FFT.
// One time-shared butterfly updates an 8-entry in-place complex buffer.
// Bins are loaded in natural order into bit-reversed addresses, 12 butterflies
// run (3 stages x 4), then samples stream out in natural order.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           bin handshake (ready only while loading)
//   in_real/in_imag   [DW-1:0]  bin, signed
//   out_valid/out_ready         sample handshake
//   out_real/out_imag [DW-1:0]  sample, signed (0 while out_valid=0)
//   out_last                    marks the 8th sample of a frame
//   ovf                         sticky saturation flag
//
// Build option: IFFT8_UNSCALED_EN removes the per-stage halving, saturates
// the butterfly outputs and drives ovf; otherwise each stage halves (1/8 total)
// and ovf is tied 0.
module ifft8_seq #(
  parameter int DW   = 16,
  parameter int TW_C = 11585
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic          out_last,
  output logic          ovf
);
  typedef enum logic [1:0] {LOAD, COMP, UNLOAD} state_t;

  state_t state_q, state_d;
  logic [2:0] in_cnt, out_cnt;
  logic [3:0] bfly_cnt;
  logic signed [DW-1:0] buf_re [8];
  logic signed [DW-1:0] buf_im [8];

  logic in_fire, out_fire;
  assign in_ready = (state_q == LOAD) && !rst;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (in_fire && in_cnt == 3'd7) state_d = COMP;
      COMP:    if (bfly_cnt == 4'd11) state_d = UNLOAD;
      UNLOAD:  if (out_fire && out_cnt == 3'd7) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // butterfly addressing: stage s, pair j
  logic [1:0] s, j, e;
  logic [2:0] top, bot;
  assign s = bfly_cnt[3:2];
  assign j = bfly_cnt[1:0];

  always_comb begin
    top = 3'd0;
    bot = 3'd0;
    e   = 2'd0;
    case (s)
      2'd0:    begin top = {j, 1'b0};          bot = {j, 1'b1};          e = 2'd0;         end
      2'd1:    begin top = {j[1], 1'b0, j[0]}; bot = {j[1], 1'b1, j[0]}; e = {j[0], 1'b0}; end
      default: begin top = {1'b0, j};          bot = {1'b1, j};          e = j;            end
    endcase
  end

  // inverse twiddle exp(+j*2*pi*e/8), Q1.14
  logic signed [15:0] w_re, w_im;
  always_comb begin
    w_re = 16'sd16384;
    w_im = 16'sd0;
    case (e)
      2'd1:    begin w_re = 16'(TW_C);  w_im = 16'(TW_C);  end
      2'd2:    begin w_re = 16'sd0;     w_im = 16'sd16384; end
      2'd3:    begin w_re = 16'(-TW_C); w_im = 16'(TW_C);  end
      default: ;
    endcase
  end

  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  assign a_re = buf_re[top];
  assign a_im = buf_im[top];
  assign b_re = buf_re[bot];
  assign b_im = buf_im[bot];

  logic signed [32:0] bre_x, bim_x, wre_x, wim_x, p_re, p_im;
  logic signed [17:0] t_re, t_im;
  logic signed [18:0] s_re, s_im, d_re, d_im;
  assign bre_x = 33'(b_re);
  assign bim_x = 33'(b_im);
  assign wre_x = 33'(w_re);
  assign wim_x = 33'(w_im);
  assign p_re  = bre_x * wre_x - bim_x * wim_x;
  assign p_im  = bre_x * wim_x + bim_x * wre_x;
  assign t_re  = 18'((p_re + 33'sd8192) >>> 14);
  assign t_im  = 18'((p_im + 33'sd8192) >>> 14);
  assign s_re  = 19'(a_re) + 19'(t_re);
  assign s_im  = 19'(a_im) + 19'(t_im);
  assign d_re  = 19'(a_re) - 19'(t_re);
  assign d_im  = 19'(a_im) - 19'(t_im);

  logic signed [DW-1:0] na_re, na_im, nb_re, nb_im;

`ifdef IFFT8_UNSCALED_EN
  localparam logic signed [18:0] MAXV = 19'((1 <<< (DW-1)) - 1);
  localparam logic signed [18:0] MINV = -19'(1 <<< (DW-1));

  function automatic logic signed [DW-1:0] sat(input logic signed [18:0] v);
    if (v > MAXV)      sat = MAXV[DW-1:0];
    else if (v < MINV) sat = MINV[DW-1:0];
    else               sat = v[DW-1:0];
  endfunction

  function automatic logic clip(input logic signed [18:0] v);
    clip = (v > MAXV) || (v < MINV);
  endfunction

  logic sat_hit, ovf_q;
  assign na_re   = sat(s_re);
  assign na_im   = sat(s_im);
  assign nb_re   = sat(d_re);
  assign nb_im   = sat(d_im);
  assign sat_hit = clip(s_re) | clip(s_im) | clip(d_re) | clip(d_im);
  assign ovf     = ovf_q;

  // first bin of a frame clears; any clipping butterfly sets
  always_ff @(posedge clk) begin
    if (rst)                            ovf_q <= 1'b0;
    else if (in_fire && in_cnt == 3'd0) ovf_q <= 1'b0;
    else if (state_q == COMP && sat_hit) ovf_q <= 1'b1;
  end
`else
  assign na_re = DW'(s_re >>> 1);
  assign na_im = DW'(s_im >>> 1);
  assign nb_re = DW'(d_re >>> 1);
  assign nb_im = DW'(d_im >>> 1);
  assign ovf   = 1'b0;
`endif

  // buffer: contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_re[{in_cnt[0], in_cnt[1], in_cnt[2]}] <= in_real;
      buf_im[{in_cnt[0], in_cnt[1], in_cnt[2]}] <= in_imag;
    end else if (state_q == COMP) begin
      buf_re[top] <= na_re;
      buf_im[top] <= na_im;
      buf_re[bot] <= nb_re;
      buf_im[bot] <= nb_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      in_cnt    <= 3'd0;
      bfly_cnt  <= 4'd0;
      out_cnt   <= 3'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) in_cnt <= in_cnt + 3'd1;
      if (state_q == COMP) bfly_cnt <= (bfly_cnt == 4'd11) ? 4'd0 : bfly_cnt + 4'd1;
      // registered output: first UNLOAD cycle loads sample 0
      if (state_q == UNLOAD) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_real  <= buf_re[out_cnt];
          out_imag  <= buf_im[out_cnt];
          out_last  <= (out_cnt == 3'd7);
        end else if (out_ready) begin
          if (out_cnt == 3'd7) begin
            out_cnt   <= 3'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
          end else begin
            out_cnt  <= out_cnt + 3'd1;
            out_real <= buf_re[out_cnt + 3'd1];
            out_imag <= buf_im[out_cnt + 3'd1];
            out_last <= (out_cnt == 3'd6);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ifft8_seq.sv
module tb_ifft8_seq;
  localparam int DW = 16;
`ifdef IFFT8_UNSCALED_EN
  localparam real SCL = 8.0;
`else
  localparam real SCL = 1.0;
`endif

  logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_last, ovf;
  logic [DW-1:0] in_real, in_imag, out_real, out_imag;

  ifft8_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_last(out_last), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][15:0] xr, xi, er, ei;
    logic [3:0]       tol;
  } vec_t;

  typedef struct {
    int re;
    int im;
    int last;
    int tol;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[4];
  int checks = 0, errors = 0, last_lat = 0;

  task automatic chk(input string name, input int act, input int req, input int tol);
    checks++;
    if (act - req > tol || req - act > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, req, tol);
    end
  endtask

  // floating-point reference: x[n] = (1/8) sum X[k] exp(+j*2*pi*k*n/8)
  function automatic vec_t model(input vec_t v);
    real re, im, ang, xr, xi;
    for (int n = 0; n < 8; n++) begin
      re = 0.0;
      im = 0.0;
      for (int k = 0; k < 8; k++) begin
        ang = 2.0 * 3.14159265358979 * k * n / 8.0;
        xr  = $signed(v.xr[k]);
        xi  = $signed(v.xi[k]);
        re += xr * $cos(ang) - xi * $sin(ang);
        im += xr * $sin(ang) + xi * $cos(ang);
      end
      v.er[n] = 16'(int'(re * SCL / 8.0));
      v.ei[n] = 16'(int'(im * SCL / 8.0));
    end
    return v;
  endfunction

  task automatic send(input vec_t v, input int gap_at, input int gap_len);
    int w;
    for (int n = 0; n < 8; n++)
      sb.push_back('{$signed(v.er[n]), $signed(v.ei[n]), (n == 7), int'(v.tol)});
    for (int k = 0; k < 8; k++) begin
      if (k == gap_at) begin
        in_valid = 1'b0;
        repeat (gap_len) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_real  = v.xr[k];
      in_imag  = v.xi[k];
      w = 0;
      while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL in_timeout: in_ready stuck at 0 for bin %0d", k);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_real  = '0;
    in_imag  = '0;
  endtask

  task automatic recv(input int stall_at);
    exp_t e;
    int w;
    logic [DW-1:0] r0, i0;
    logic l0;
    out_ready = 1'b1;
    last_lat = 0;
    while (!out_valid && last_lat < 100) begin @(posedge clk); #1; last_lat++; end
    for (int i = 0; i < 8; i++) begin
      w = 0;
      while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
      if (!out_valid) begin
        checks++; errors++;
        $display("FAIL out_timeout: out_valid low waiting for sample %0d", i);
        return;
      end
      if (i == stall_at) begin
        out_ready = 1'b0;
        r0 = out_real; i0 = out_imag; l0 = out_last;
        repeat (5) begin
          @(posedge clk); #1;
          chk("stall_valid", int'(out_valid), 1, 0);
          chk("stall_re", int'(out_real), int'(r0), 0);
          chk("stall_im", int'(out_imag), int'(i0), 0);
          chk("stall_last", int'(out_last), int'(l0), 0);
          chk("stall_in_ready", int'(in_ready), 0, 0);
        end
        out_ready = 1'b1;
      end
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: unexpected sample %0d", i);
        return;
      end
      e = sb.pop_front();
      chk($sformatf("re[%0d]", i), int'($signed(out_real)), e.re, e.tol);
      chk($sformatf("im[%0d]", i), int'($signed(out_imag)), e.im, e.tol);
      chk($sformatf("last[%0d]", i), int'(out_last), e.last, 0);
      chk("unload_in_ready", int'(in_ready), 0, 0);
      @(posedge clk); #1;
    end
    chk("post_in_ready", int'(in_ready), 1, 0);
    chk("post_out_valid", int'(out_valid), 0, 0);
    chk("post_out_real", int'(out_real), 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    vec_t sv;
    int xr4[8] = '{1000, 300, -700, 50, 400, -250, 900, -100};
    int xi4[8] = '{-200, 500, 100, -900, 400, 600, -300, -50};

    tbl[0] = '0; tbl[0].xr[0] = 16'd8000;                     // impulse
    tbl[1] = '0; tbl[1].xr[1] = 16'd8192; tbl[1].tol = 4'd1;  // single tone
    tbl[2] = '0;                                              // constant spectrum
    for (int k = 0; k < 8; k++) begin
      tbl[2].xr[k] = 16'(800);
      tbl[2].xi[k] = 16'(-400);
      tbl[3].xr[k] = 16'(xr4[k]);
      tbl[3].xi[k] = 16'(xi4[k]);
    end
    tbl[3].tol = 4'd3;
    for (int v = 0; v < 4; v++) tbl[v] = model(tbl[v]);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_real = '0; in_imag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_in_ready", int'(in_ready), 0, 0);
    chk("rst_out_last", int'(out_last), 0, 0);
    chk("rst_ovf", int'(ovf), 0, 0);
    chk("rst_out_real", int'(out_real), 0, 0);
    chk("rst_out_imag", int'(out_imag), 0, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", int'(in_ready), 1, 0);

    for (int v = 0; v < 4; v++) begin
      send(tbl[v], (v == 1) ? 3 : -1, 2);
      chk("comp_in_ready", int'(in_ready), 0, 0);
      recv((v == 1) ? 3 : -1);
      chk("latency", last_lat, 13, 0);
`ifndef IFFT8_UNSCALED_EN
      chk("ovf_tied", int'(ovf), 0, 0);
`endif
    end

    // reset pulse in the middle of COMP discards the frame
    send(tbl[0], -1, 0);
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", int'(in_ready), 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0, 0);
    chk("midrst_in_ready_rel", int'(in_ready), 1, 0);
    sb.delete();
    seen = 0;
    out_ready = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    chk("midrst_no_partial", seen, 0, 0);
    send(tbl[0], -1, 0);
    recv(-1);
    chk("midrst_latency", last_lat, 13, 0);

`ifdef IFFT8_UNSCALED_EN
    sv = '0;
    for (int k = 0; k < 8; k++) sv.xr[k] = 16'(20000);
    sv.er[0] = 16'(32767);
    send(sv, -1, 0);
    recv(-1);
    chk("ovf_set", int'(ovf), 1, 0);
    send(tbl[0], -1, 0);
    chk("ovf_clear", int'(ovf), 0, 0);
    recv(-1);
`else
    sv = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
